// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 set-2 keyboard definitions: prefix/modifier scancodes, the prefix
// FSM state type and the scancode-to-ASCII lookup.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } prefix_state_t;

    // Returns {hit, char}; letters are stored uppercase and folded to lowercase
    // by setting bit 5 when upper=0.
    function automatic logic [8:0] ascii_lookup(input logic [7:0] code,
                                                input logic       shifted,
                                                input logic       upper);
        logic       hit;
        logic       is_letter;
        logic [7:0] plain;
        logic [7:0] shf;
        hit       = 1'b1;
        is_letter = 1'b0;
        plain     = 8'h00;
        shf       = 8'h00;
        case (code)
            8'h1C: begin is_letter = 1'b1; plain = "A"; end
            8'h32: begin is_letter = 1'b1; plain = "B"; end
            8'h21: begin is_letter = 1'b1; plain = "C"; end
            8'h23: begin is_letter = 1'b1; plain = "D"; end
            8'h24: begin is_letter = 1'b1; plain = "E"; end
            8'h2B: begin is_letter = 1'b1; plain = "F"; end
            8'h34: begin is_letter = 1'b1; plain = "G"; end
            8'h33: begin is_letter = 1'b1; plain = "H"; end
            8'h43: begin is_letter = 1'b1; plain = "I"; end
            8'h3B: begin is_letter = 1'b1; plain = "J"; end
            8'h42: begin is_letter = 1'b1; plain = "K"; end
            8'h4B: begin is_letter = 1'b1; plain = "L"; end
            8'h3A: begin is_letter = 1'b1; plain = "M"; end
            8'h31: begin is_letter = 1'b1; plain = "N"; end
            8'h44: begin is_letter = 1'b1; plain = "O"; end
            8'h4D: begin is_letter = 1'b1; plain = "P"; end
            8'h15: begin is_letter = 1'b1; plain = "Q"; end
            8'h2D: begin is_letter = 1'b1; plain = "R"; end
            8'h1B: begin is_letter = 1'b1; plain = "S"; end
            8'h2C: begin is_letter = 1'b1; plain = "T"; end
            8'h3C: begin is_letter = 1'b1; plain = "U"; end
            8'h2A: begin is_letter = 1'b1; plain = "V"; end
            8'h1D: begin is_letter = 1'b1; plain = "W"; end
            8'h22: begin is_letter = 1'b1; plain = "X"; end
            8'h35: begin is_letter = 1'b1; plain = "Y"; end
            8'h1A: begin is_letter = 1'b1; plain = "Z"; end
            8'h45: begin plain = "0"; shf = ")"; end
            8'h16: begin plain = "1"; shf = "!"; end
            8'h1E: begin plain = "2"; shf = "@"; end
            8'h26: begin plain = "3"; shf = "#"; end
            8'h25: begin plain = "4"; shf = "$"; end
            8'h2E: begin plain = "5"; shf = "%"; end
            8'h36: begin plain = "6"; shf = "^"; end
            8'h3D: begin plain = "7"; shf = "&"; end
            8'h3E: begin plain = "8"; shf = "*"; end
            8'h46: begin plain = "9"; shf = "("; end
            8'h29: begin plain = 8'h20; shf = 8'h20; end
            8'h5A: begin plain = 8'h0D; shf = 8'h0D; end
            8'h66: begin plain = 8'h08; shf = 8'h08; end
            default: hit = 1'b0;
        endcase
        if (!hit)
            return 9'h000;
        if (is_letter)
            return {1'b1, upper ? plain : (plain | 8'h20)};
        return {1'b1, shifted ? shf : plain};
    endfunction

endpackage

// File: rtl/kbd_char_fifo.sv
// Character queue: power-of-two circular buffer with occupancy counter and a
// registered overflow pulse for pushes rejected while full.
module kbd_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    // A pop while full frees the slot the simultaneous push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count    <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            overflow <= push && !do_push;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: tracks break/extended prefixes and shift/caps
// state, translates make codes to ASCII and queues them for the consumer.
module ps2_key_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LOWER_CASE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       shift_active,
    output logic       caps_active,
    output logic       overflow
);

    prefix_state_t state;
    prefix_state_t state_nxt;
    logic          is_make;
    logic          is_break;
    logic          lshift;
    logic          rshift;
    logic          caps;
    logic          upper;
    logic [8:0]    lookup;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        is_make   = 1'b0;
        is_break  = 1'b0;
        if (code_valid) begin
            case (state)
                ST_IDLE: begin
                    if (code_in == SC_BREAK)
                        state_nxt = ST_BRK;
                    else if (code_in == SC_EXT)
                        state_nxt = ST_EXT;
                    else
                        is_make = 1'b1;
                end
                ST_BRK: begin
                    is_break  = 1'b1;
                    state_nxt = ST_IDLE;
                end
                ST_EXT:
                    state_nxt = (code_in == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                default:
                    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
            caps   <= 1'b0;
        end else begin
            if (is_make && code_in == SC_LSHIFT)
                lshift <= 1'b1;
            else if (is_break && code_in == SC_LSHIFT)
                lshift <= 1'b0;
            if (is_make && code_in == SC_RSHIFT)
                rshift <= 1'b1;
            else if (is_break && code_in == SC_RSHIFT)
                rshift <= 1'b0;
            if (is_make && code_in == SC_CAPS)
                caps <= ~caps;
        end
    end

    assign shift_active = lshift | rshift;
    assign caps_active  = caps;

    // Mapping uses the registered modifiers, i.e. the state before this byte.
    assign upper  = (LOWER_CASE != 0) ? (shift_active ^ caps) : 1'b1;
    assign lookup = ascii_lookup(code_in, shift_active, upper);
    assign push   = is_make && lookup[8];

    kbd_char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      (lookup[7:0]),
        .full     (fifo_full),
        .pop      (ascii_ready),
        .dout     (ascii_out),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign ascii_valid = !fifo_empty;

endmodule
